// File: rtl/counter_snapshot_tx.sv
// Snapshots two counter values on request and streams them out as a framed byte sequence
// (header, counter 0 LSB-first, counter 1 LSB-first, XOR checksum) over a valid/ready link.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no frame in progress, waiting for Req
// S_HDR  | presenting the constant header byte
// S_C0   | presenting counter 0 snapshot bytes, LSB first
// S_C1   | presenting counter 1 snapshot bytes, LSB first
// S_SUM  | presenting the checksum byte with TxLast; Req here chains a new frame
module counter_snapshot_tx #(
   parameter int             CNT_W    = 64,
   parameter logic [7:0]     HDR_BYTE = 8'hA5
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [CNT_W-1:0] Cnt0,
   input  logic [CNT_W-1:0] Cnt1,
   input  logic             Req,
   output logic             Busy,
   output logic [7:0]       TxData,
   output logic             TxValid,
   input  logic             TxReady,
   output logic             TxLast,
   output logic [7:0]       Dropped
);

   localparam int            NB       = CNT_W / 8;
   localparam int            BW       = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [BW-1:0] LAST_IDX = BW'(NB - 1);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_C0, S_C1, S_SUM} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] snap0, snap1;
   logic [BW-1:0]    byte_cnt;
   logic [7:0]       sum, sum_new;
   logic             xfer, start, last_byte;

   assign xfer      = TxValid && TxReady;
   assign last_byte = (byte_cnt == '0);

   always_comb begin
      sum_new = HDR_BYTE;
      for (int i = 0; i < NB; i++) begin
         sum_new = sum_new ^ Cnt0[i*8 +: 8] ^ Cnt1[i*8 +: 8];
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         S_IDLE: if (Req) begin
            start     = 1'b1;
            state_nxt = S_HDR;
         end
         S_HDR:  if (xfer) state_nxt = S_C0;
         S_C0:   if (xfer && last_byte) state_nxt = S_C1;
         S_C1:   if (xfer && last_byte) state_nxt = S_SUM;
         S_SUM:  if (xfer) begin
            if (Req) begin
               start     = 1'b1;
               state_nxt = S_HDR;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decode straight from state so an async reset clears them immediately.
   always_comb begin
      TxValid = (state != S_IDLE);
      Busy    = (state != S_IDLE);
      TxLast  = (state == S_SUM);
      case (state)
         S_HDR:   TxData = HDR_BYTE;
         S_C0:    TxData = snap0[7:0];
         S_C1:    TxData = snap1[7:0];
         S_SUM:   TxData = sum;
         default: TxData = 8'h00;
      endcase
   end

   // Snapshots shift right as bytes leave, so the current byte is always bits [7:0].
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         snap0    <= '0;
         snap1    <= '0;
         byte_cnt <= '0;
         sum      <= 8'h00;
      end else if (start) begin
         snap0 <= Cnt0;
         snap1 <= Cnt1;
         sum   <= sum_new;
      end else if (xfer) begin
         case (state)
            S_HDR: byte_cnt <= LAST_IDX;
            S_C0: begin
               snap0    <= snap0 >> 8;
               byte_cnt <= last_byte ? LAST_IDX : byte_cnt - 1'b1;
            end
            S_C1: begin
               snap1    <= snap1 >> 8;
               byte_cnt <= byte_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         Dropped <= 8'h00;
      else if (Req && Busy && !start && Dropped != 8'hFF)
         Dropped <= Dropped + 8'h01;
   end

endmodule

// File: tb/tb_counter_snapshot_tx.sv
// Randomized bench for counter_snapshot_tx; expected frames come from a byte-list model
// built by plain arithmetic on the requested counter values.
module tb_counter_snapshot_tx;

   typedef logic [7:0] bq_t[$];
   typedef logic       lq_t[$];

   logic        Clk, Reset, Req, TxReady;
   logic [63:0] Cnt0, Cnt1;
   logic        Busy, TxValid, TxLast;
   logic [7:0]  TxData, Dropped;

   int checks   = 0;
   int failures = 0;
   int exp_drop = 0;

   counter_snapshot_tx #(.CNT_W(64), .HDR_BYTE(8'hA5)) dut (
      .Clk(Clk), .Reset(Reset), .Cnt0(Cnt0), .Cnt1(Cnt1), .Req(Req),
      .Busy(Busy), .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
      .TxLast(TxLast), .Dropped(Dropped)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic model_frame(input logic [63:0] c0, input logic [63:0] c1, output bq_t f);
      logic [7:0] s;
      f = {};
      f.push_back(8'hA5);
      for (int i = 0; i < 8; i++) f.push_back(8'((c0 >> (8*i)) & 64'hFF));
      for (int i = 0; i < 8; i++) f.push_back(8'((c1 >> (8*i)) & 64'hFF));
      s = 8'h00;
      foreach (f[k]) s = s ^ f[k];
      f.push_back(s);
   endtask

   // Called at #1 after an edge with idle DUT; returns #1 after the latch edge.
   task automatic start_frame(input logic [63:0] c0, input logic [63:0] c1);
      Cnt0 = c0;
      Cnt1 = c1;
      Req  = 1'b1;
      @(posedge Clk);
      #1;
      Req = 1'b0;
   endtask

   // Gathers bytes until TxLast transfers; counts stability/valid violations while stalled.
   task automatic collect(input int pct, input logic [31:0] req_mask, input bit incr0,
                          output bq_t dq, output lq_t lq, output int stall_err,
                          output bit timeout);
      logic [7:0] hold_d;
      logic       hold_l;
      bit         holding;
      dq = {};
      lq = {};
      stall_err = 0;
      timeout   = 1'b1;
      holding   = 1'b0;
      hold_d    = 8'h00;
      hold_l    = 1'b0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (TxValid !== 1'b1) stall_err++;
         if (holding && (TxData !== hold_d || TxLast !== hold_l)) stall_err++;
         TxReady = ($urandom_range(99) < pct);
         Req     = (dq.size() < 32) ? req_mask[dq.size()] : 1'b0;
         if (TxValid && TxReady) begin
            dq.push_back(TxData);
            lq.push_back(TxLast);
            holding = 1'b0;
         end else begin
            holding = 1'b1;
            hold_d  = TxData;
            hold_l  = TxLast;
         end
         @(posedge Clk);
         #1;
         Req = 1'b0;
         if (incr0) Cnt0 = Cnt0 + 64'd1;
         if (lq.size() > 0 && lq[lq.size()-1] === 1'b1) begin
            timeout = 1'b0;
            break;
         end
      end
      TxReady = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (TxValid !== 1'b0) begin failures++; $display("FAIL reset_txvalid got=%b exp=0", TxValid); end
      checks++; if (Busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
      checks++; if (TxLast !== 1'b0)  begin failures++; $display("FAIL reset_txlast got=%b exp=0", TxLast); end
      checks++; if (TxData !== 8'h00) begin failures++; $display("FAIL reset_txdata got=%h exp=00", TxData); end
      checks++; if (Dropped !== 8'h00) begin failures++; $display("FAIL reset_dropped got=%h exp=00", Dropped); end
   endtask

   task automatic test_basic();
      bq_t exp, dq;
      lq_t lq;
      int  serr;
      bit  to;
      model_frame(64'h0102, 64'h03, exp);
      start_frame(64'h0102, 64'h03);
      checks++; if (TxValid !== 1'b1 || TxData !== 8'hA5)
         begin failures++; $display("FAIL basic_hdr_latency got=%b/%h exp=1/a5", TxValid, TxData); end
      collect(100, 32'h0, 1'b0, dq, lq, serr, to);
      checks++; if (to || dq.size() != 18) begin failures++; $display("FAIL basic_len got=%0d exp=18 timeout=%0d", dq.size(), to); end
      for (int i = 0; i < dq.size() && i < 18; i++) begin
         checks++; if (dq[i] !== exp[i]) begin failures++; $display("FAIL basic_byte[%0d] got=%h exp=%h", i, dq[i], exp[i]); end
         checks++; if (lq[i] !== (i == 17)) begin failures++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, lq[i], i == 17); end
      end
      checks++; if (exp[17] !== 8'hA5) begin failures++; $display("FAIL basic_model_sum got=%h exp=a5", exp[17]); end
      checks++; if (serr != 0) begin failures++; $display("FAIL basic_valid_hold got=%0d exp=0", serr); end
      checks++; if (Busy !== 1'b0 || TxValid !== 1'b0)
         begin failures++; $display("FAIL basic_idle_after got=%b/%b exp=0/0", Busy, TxValid); end
   endtask

   task automatic test_backpressure();
      bq_t exp, dq;
      lq_t lq;
      int  serr;
      bit  to;
      logic [63:0] c0, c1;
      for (int it = 0; it < 4; it++) begin
         c0 = (it == 0) ? 64'h0102 : {$urandom, $urandom};
         c1 = (it == 0) ? 64'h03   : {$urandom, $urandom};
         model_frame(c0, c1, exp);
         start_frame(c0, c1);
         collect(50, 32'h0, 1'b0, dq, lq, serr, to);
         checks++; if (to || dq.size() != 18) begin failures++; $display("FAIL bp_len it=%0d got=%0d exp=18", it, dq.size()); end
         for (int i = 0; i < dq.size() && i < 18; i++) begin
            checks++; if (dq[i] !== exp[i] || lq[i] !== (i == 17))
               begin failures++; $display("FAIL bp_byte it=%0d [%0d] got=%h/%b exp=%h/%b", it, i, dq[i], lq[i], exp[i], i == 17); end
         end
         checks++; if (serr != 0) begin failures++; $display("FAIL bp_stall_stable it=%0d got=%0d exp=0", it, serr); end
      end
   endtask

   task automatic test_back_to_back();
      bq_t exp1, exp2, dq;
      lq_t lq;
      int  serr;
      bit  to;
      logic [63:0] c0, c1, n1;
      c0 = {$urandom, $urandom};
      c1 = {$urandom, $urandom};
      n1 = {$urandom, $urandom};
      model_frame(c0, c1, exp1);
      model_frame(64'd5, n1, exp2);
      start_frame(c0, c1);
      Cnt0 = 64'd5;
      Cnt1 = n1;
      collect(100, 32'h0002_0000, 1'b0, dq, lq, serr, to);
      checks++; if (to || dq.size() != 18) begin failures++; $display("FAIL b2b_len1 got=%0d exp=18", dq.size()); end
      for (int i = 0; i < dq.size() && i < 18; i++) begin
         checks++; if (dq[i] !== exp1[i]) begin failures++; $display("FAIL b2b_frame1[%0d] got=%h exp=%h", i, dq[i], exp1[i]); end
      end
      checks++; if (TxValid !== 1'b1 || TxData !== 8'hA5 || Busy !== 1'b1)
         begin failures++; $display("FAIL b2b_no_gap got=%b/%h/%b exp=1/a5/1", TxValid, TxData, Busy); end
      checks++; if (Dropped !== 8'(exp_drop)) begin failures++; $display("FAIL b2b_dropped got=%h exp=%h", Dropped, 8'(exp_drop)); end
      collect(100, 32'h0, 1'b0, dq, lq, serr, to);
      checks++; if (to || dq.size() != 18) begin failures++; $display("FAIL b2b_len2 got=%0d exp=18", dq.size()); end
      for (int i = 0; i < dq.size() && i < 18; i++) begin
         checks++; if (dq[i] !== exp2[i]) begin failures++; $display("FAIL b2b_frame2[%0d] got=%h exp=%h", i, dq[i], exp2[i]); end
      end
   endtask

   task automatic test_drops();
      bq_t exp, dq;
      lq_t lq;
      int  serr;
      bit  to;
      logic [63:0] c0, c1;
      c0 = {$urandom, $urandom};
      c1 = {$urandom, $urandom};
      model_frame(c0, c1, exp);
      start_frame(c0, c1);
      collect(100, 32'h0000_00A8, 1'b0, dq, lq, serr, to);
      exp_drop = exp_drop + 3;
      checks++; if (Dropped !== 8'(exp_drop)) begin failures++; $display("FAIL drops_three got=%h exp=%h", Dropped, 8'(exp_drop)); end
      checks++; if (to || dq.size() != 18) begin failures++; $display("FAIL drops_len got=%0d exp=18", dq.size()); end
      for (int i = 0; i < dq.size() && i < 18; i++) begin
         checks++; if (dq[i] !== exp[i]) begin failures++; $display("FAIL drops_byte[%0d] got=%h exp=%h", i, dq[i], exp[i]); end
      end
      c0 = {$urandom, $urandom};
      model_frame(c0, c1, exp);
      start_frame(c0, c1);
      TxReady = 1'b0;
      Req     = 1'b1;
      repeat (300) @(posedge Clk);
      #1;
      Req = 1'b0;
      exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
      collect(100, 32'h0, 1'b0, dq, lq, serr, to);
      checks++; if (Dropped !== 8'(exp_drop)) begin failures++; $display("FAIL drops_saturate got=%h exp=%h", Dropped, 8'(exp_drop)); end
      checks++; if (to || dq.size() != 18 || dq[17] !== exp[17])
         begin failures++; $display("FAIL drops_frame2 len=%0d exp=18 timeout=%0d", dq.size(), to); end
   endtask

   task automatic test_snapshot();
      bq_t exp, dq;
      lq_t lq;
      int  serr;
      bit  to;
      logic [63:0] c1;
      c1 = {$urandom, $urandom};
      model_frame(64'hFF, c1, exp);
      start_frame(64'hFF, c1);
      Cnt0 = Cnt0 + 64'd1;
      collect(70, 32'h0, 1'b1, dq, lq, serr, to);
      checks++; if (to || dq.size() != 18) begin failures++; $display("FAIL snap_len got=%0d exp=18", dq.size()); end
      for (int i = 0; i < dq.size() && i < 18; i++) begin
         checks++; if (dq[i] !== exp[i]) begin failures++; $display("FAIL snap_byte[%0d] got=%h exp=%h", i, dq[i], exp[i]); end
      end
   endtask

   task automatic test_reset_mid();
      bq_t exp, dq;
      lq_t lq;
      int  serr;
      bit  to;
      logic [63:0] c0, c1;
      start_frame({$urandom, $urandom}, {$urandom, $urandom});
      TxReady = 1'b1;
      repeat (7) begin @(posedge Clk); #1; end
      TxReady = 1'b0;
      #2;
      Reset = 1'b1;
      #1;
      checks++; if (TxValid !== 1'b0 || Busy !== 1'b0 || TxLast !== 1'b0)
         begin failures++; $display("FAIL rstmid_async got=%b/%b/%b exp=0/0/0", TxValid, Busy, TxLast); end
      checks++; if (Dropped !== 8'h00) begin failures++; $display("FAIL rstmid_dropped got=%h exp=00", Dropped); end
      exp_drop = 0;
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      @(posedge Clk);
      #1;
      c0 = {$urandom, $urandom};
      c1 = {$urandom, $urandom};
      model_frame(c0, c1, exp);
      start_frame(c0, c1);
      collect(100, 32'h0, 1'b0, dq, lq, serr, to);
      checks++; if (to || dq.size() != 18) begin failures++; $display("FAIL rstmid_len got=%0d exp=18", dq.size()); end
      for (int i = 0; i < dq.size() && i < 18; i++) begin
         checks++; if (dq[i] !== exp[i] || lq[i] !== (i == 17))
            begin failures++; $display("FAIL rstmid_byte[%0d] got=%h/%b exp=%h/%b", i, dq[i], lq[i], exp[i], i == 17); end
      end
   endtask

   initial begin
      Reset   = 1'b1;
      Req     = 1'b0;
      TxReady = 1'b0;
      Cnt0    = 64'h0;
      Cnt1    = 64'h0;
      #3;
      test_reset();
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      @(posedge Clk);
      #1;
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_drops();
      test_snapshot();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
